// File: rtl/downwell_pkg.sv
// Shared screen geometry, coordinate widths and the player motion FSM states.
package downwell_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 4;
  localparam int SPRITE_H = 4;

  localparam int X_W = 8;
  localparam int Y_W = 7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HORIZ,
    S_VERT,
    S_COMMIT
  } motion_state_t;

endpackage

// File: rtl/frame_divider.sv
// Free-running divider producing a registered one-cycle pulse every FRAME_DIV clocks.
module frame_divider #(
  parameter int unsigned FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic frame_tick
);

  localparam int unsigned CW = $clog2(FRAME_DIV);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count      <= '0;
      frame_tick <= 1'b0;
    end else if (count == CW'(FRAME_DIV - 1)) begin
      count      <= '0;
      frame_tick <= 1'b1;
    end else begin
      count      <= count + CW'(1);
      frame_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/player_motion.sv
// Per-frame player physics: horizontal move, jump/gravity, clamp, then hold the
// result pending until the draw engine takes it with a next pulse.
module player_motion
  import downwell_pkg::*;
#(
  parameter int unsigned        FRAME_DIV = 833333,
  parameter logic [X_W-1:0]     X_START   = 8'd3,
  parameter logic [Y_W-1:0]     Y_START   = 7'd3,
  parameter logic [X_W-1:0]     X_MIN     = 8'd0,
  parameter logic [X_W-1:0]     X_MAX     = X_W'(SCREEN_W - SPRITE_W),
  parameter logic [Y_W-1:0]     Y_MIN     = 7'd0,
  parameter logic [Y_W-1:0]     Y_MAX     = Y_W'(SCREEN_H - SPRITE_H),
  parameter logic signed [3:0]  JUMP_VEL  = -4'sd4,
  parameter logic signed [3:0]  MAX_FALL  = 4'sd3
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           left,
  input  logic           right,
  input  logic           jump,
  input  logic           next,
  output logic [X_W-1:0] x_out,
  output logic [Y_W-1:0] y_out,
  output logic           pending,
  output logic           grounded,
  output logic           frame_tick
);

  motion_state_t      state;
  logic [X_W-1:0]     px;
  logic [Y_W-1:0]     py;
  logic signed [3:0]  vy;
  logic signed [8:0]  ny;
  logic               jump_req;
  logic               jump_d;
  logic signed [3:0]  vy_new;
  logic signed [8:0]  ny_new;

  frame_divider #(.FRAME_DIV(FRAME_DIV)) u_div (
    .clk        (clk),
    .resetn     (resetn),
    .frame_tick (frame_tick)
  );

  always_comb begin
    vy_new = vy;
    if (jump_req && grounded)
      vy_new = JUMP_VEL;
    else if (vy >= MAX_FALL)
      vy_new = MAX_FALL;
    else
      vy_new = vy + 4'sd1;
    ny_new = $signed({2'b00, py}) + {{5{vy_new[3]}}, vy_new};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      px       <= X_START;
      py       <= Y_START;
      vy       <= '0;
      ny       <= '0;
      jump_req <= 1'b0;
      jump_d   <= 1'b0;
      x_out    <= X_START;
      y_out    <= Y_START;
      pending  <= 1'b0;
      grounded <= 1'b0;
    end else begin
      jump_d <= jump;
      // A fresh jump edge wins over the S_VERT clear so it is never lost.
      if (jump && !jump_d)
        jump_req <= 1'b1;
      else if (state == S_VERT)
        jump_req <= 1'b0;

      // Publishing reads px/py before any commit on this edge lands.
      if (next && pending) begin
        x_out <= px;
        y_out <= py;
      end
      if (state == S_COMMIT)
        pending <= 1'b1;
      else if (next)
        pending <= 1'b0;

      unique case (state)
        S_IDLE: begin
          if (frame_tick)
            state <= S_HORIZ;
        end
        S_HORIZ: begin
          if (left && !right)
            px <= (px <= X_MIN) ? X_MIN : px - 1'b1;
          else if (right && !left)
            px <= (px >= X_MAX) ? X_MAX : px + 1'b1;
          state <= S_VERT;
        end
        S_VERT: begin
          vy <= vy_new;
          ny <= ny_new;
          if (jump_req && grounded)
            grounded <= 1'b0;
          state <= S_COMMIT;
        end
        S_COMMIT: begin
          if (ny >= $signed({2'b00, Y_MAX})) begin
            py       <= Y_MAX;
            vy       <= '0;
            grounded <= 1'b1;
          end else if (ny <= $signed({2'b00, Y_MIN})) begin
            py <= Y_MIN;
            vy <= '0;
          end else begin
            py       <= ny[Y_W-1:0];
            grounded <= 1'b0;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
